// File: rtl/avfcl_pkg.sv
// Shared types and constants for the AVF residency accumulator.
package avfcl_pkg;

   localparam int DURATION_WIDTH = 10;

   // Snapshot fields are sized for the widest supported accumulator/counter;
   // the top slices them down to its own ACC_W / CNT_W.
   localparam int SNAP_ACC_W = 32;
   localparam int SNAP_CNT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } avf_state_e;

   typedef struct packed {
      logic [SNAP_ACC_W-1:0] sum;
      logic [SNAP_ACC_W-1:0] nonace_sum;
      logic [SNAP_CNT_W-1:0] count;
      logic                  sat;
   } avf_snap_t;

endpackage

// File: rtl/ib_avf_accum_sat_accum.sv
// Saturating accumulator with synchronous clear and sticky saturation flag.
// Exposes the next-state sum so a snapshot can include a same-cycle add.
module sat_accum #(
   parameter int W    = 32,
   parameter int IN_W = 10
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            en,
   input  logic [IN_W-1:0] add,
   output logic [W-1:0]    sum_nxt,
   output logic            sat_nxt
);

   logic [W-1:0] sum;
   logic         sat;
   logic [W:0]   wide;

   assign wide = {1'b0, sum} + (W+1)'(add);

   // Clamp to all-ones on carry-out and latch the saturation flag.
   always_comb begin
      sum_nxt = sum;
      sat_nxt = sat;
      if (en) begin
         if (wide[W]) begin
            sum_nxt = '1;
            sat_nxt = 1'b1;
         end else begin
            sum_nxt = wide[W-1:0];
         end
      end
   end

   // Accumulator state; clear has priority over the add.
   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         sum <= '0;
         sat <= 1'b0;
      end else begin
         sum <= sum_nxt;
         sat <= sat_nxt;
      end
   end

endmodule

// File: rtl/ib_avf_accum.sv
// Per-epoch ACE residency accumulator feeding the AVF readout.
// Optional feature: define IB_AVF_NONACE_EN to build the non-ACE accumulator;
// otherwise avf_nonace_sum reads 0.
//
// state | meaning
// IDLE  | timer held at 0, pops ignored, waiting for start
// RUN   | timer counts 0..EPOCH_CYCLES-1, snapshot at terminal count or stop
module ib_avf_accum
   import avfcl_pkg::*;
#(
   parameter int DUR_W        = DURATION_WIDTH,
   parameter int ACC_W        = 32,
   parameter int CNT_W        = 16,
   parameter int EPOCH_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pop,
   input  logic             ace,
   input  logic             squash,
   input  logic [DUR_W-1:0] ib_duration,
   output logic [ACC_W-1:0] avf_sum,
   output logic [ACC_W-1:0] avf_nonace_sum,
   output logic [CNT_W-1:0] avf_count,
   output logic             avf_sat,
   output logic             avf_valid,
   input  logic             avf_ready,
   output logic             overrun
);

   localparam int TMR_W = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TC = TMR_W'(EPOCH_CYCLES - 1);

   avf_state_e       state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ACC_W-1:0] acc_nxt;
   logic             acc_sat_nxt;
   logic [ACC_W-1:0] non_nxt;
   logic             running;
   logic             qual;
   logic             snap;
   avf_snap_t        snap_d;
   avf_snap_t        snap_q;

   assign running = (state == RUN);
   assign qual    = running & pop & ~squash & ace;
   assign snap    = running & ((timer == TC) | stop);

   sat_accum #(.W(ACC_W), .IN_W(DUR_W)) u_ace_accum (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (snap),
      .en      (qual),
      .add     (ib_duration),
      .sum_nxt (acc_nxt),
      .sat_nxt (acc_sat_nxt)
   );

`ifdef IB_AVF_NONACE_EN
   logic unqual;
   logic non_sat_nxt;

   assign unqual = running & pop & (squash | ~ace);

   sat_accum #(.W(ACC_W), .IN_W(DUR_W)) u_nonace_accum (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (snap),
      .en      (unqual),
      .add     (ib_duration),
      .sum_nxt (non_nxt),
      .sat_nxt (non_sat_nxt)
   );
`else
   assign non_nxt = '0;
`endif

   assign cnt_nxt = (qual && (cnt != '1)) ? cnt + 1'b1 : cnt;

   // Epoch sequencing: timer runs only in RUN and wraps at terminal count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         case (state)
            IDLE: begin
               timer <= '0;
               if (start && !stop) state <= RUN;
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (timer == TC) begin
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   // Saturating ACE pop counter, cleared at each snapshot.
   always_ff @(posedge clk) begin
      if (!reset_n || snap) cnt <= '0;
      else                  cnt <= cnt_nxt;
   end

   // Snapshot payload includes any pop landing in the snapshot cycle.
   always_comb begin
      snap_d            = '0;
      snap_d.sum        = SNAP_ACC_W'(acc_nxt);
      snap_d.nonace_sum = SNAP_ACC_W'(non_nxt);
      snap_d.count      = SNAP_CNT_W'(cnt_nxt);
      snap_d.sat        = acc_sat_nxt;
   end

   // Output snapshot register and valid/ready handshake with sticky overrun.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         snap_q    <= '0;
         avf_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (snap) begin
         snap_q    <= snap_d;
         avf_valid <= 1'b1;
         if (avf_valid && !avf_ready) overrun <= 1'b1;
      end else if (avf_ready) begin
         avf_valid <= 1'b0;
      end
   end

   assign avf_sum        = snap_q.sum[ACC_W-1:0];
   assign avf_nonace_sum = snap_q.nonace_sum[ACC_W-1:0];
   assign avf_count      = snap_q.count[CNT_W-1:0];
   assign avf_sat        = snap_q.sat;

endmodule

// File: tb/tb_ib_avf_accum.sv
// Randomized scoreboard bench for ib_avf_accum with a behavioural epoch model.
module tb_ib_avf_accum;

   localparam int E    = 16;
   localparam int AW   = 12;
   localparam int CW   = 16;
   localparam int MAXS = (1 << AW) - 1;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, stop, pop, ace, squash, avf_ready;
   logic [9:0]    ib_duration;
   logic [AW-1:0] avf_sum, avf_nonace_sum;
   logic [CW-1:0] avf_count;
   logic          avf_sat, avf_valid, overrun;

   always #5 clk = ~clk;

   ib_avf_accum #(.DUR_W(10), .ACC_W(AW), .CNT_W(CW), .EPOCH_CYCLES(E)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .stop           (stop),
      .pop            (pop),
      .ace            (ace),
      .squash         (squash),
      .ib_duration    (ib_duration),
      .avf_sum        (avf_sum),
      .avf_nonace_sum (avf_nonace_sum),
      .avf_count      (avf_count),
      .avf_sat        (avf_sat),
      .avf_valid      (avf_valid),
      .avf_ready      (avf_ready),
      .overrun        (overrun)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int sum;
      int non;
      int cnt;
      bit sat;
      bit ovr;
   } snap_s;

   snap_s sb[$];

   // Reference model: epoch-level bookkeeping in plain integers.
   bit m_run;
   int m_timer, m_sum, m_non, m_cnt;
   bit m_sat, m_valid, m_valid_nxt, m_ovr;
   bit rdy;
   bit mon_en = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      return (v > MAXS) ? MAXS : v;
   endfunction

   task automatic model_clear();
      m_run = 0; m_timer = 0; m_sum = 0; m_non = 0; m_cnt = 0;
      m_sat = 0; m_ovr = 0; m_valid_nxt = 0;
      sb.delete();
   endtask

   task automatic step(input bit st, input bit sp, input bit p, input bit a,
                       input bit sq, input int d);
      bit qual, nq, snapn;
      int nsum, nnon, ncnt;
      bit nsat;
      start = st; stop = sp; pop = p; ace = a; squash = sq;
      ib_duration = 10'(d); avf_ready = rdy;
      qual  = m_run && p && !sq && a;
      nq    = m_run && p && !qual;
      nsum  = m_sum; nnon = m_non; ncnt = m_cnt; nsat = m_sat;
      if (qual) begin
         if (nsum + d > MAXS) nsat = 1;
         nsum = clamp(nsum + d);
         if (ncnt < MAXC) ncnt = ncnt + 1;
      end
      if (nq) nnon = clamp(nnon + d);
      snapn = m_run && ((m_timer == E - 1) || sp);
      m_valid_nxt = m_valid && !rdy;
      if (snapn) begin
         if (m_valid && !rdy) begin
            m_ovr = 1;
            sb.delete(sb.size() - 1);
         end
         sb.push_back('{nsum, nnon, ncnt, nsat, m_ovr});
         m_valid_nxt = 1;
         nsum = 0; nnon = 0; ncnt = 0; nsat = 0;
      end
      m_sum = nsum; m_non = nnon; m_cnt = ncnt; m_sat = nsat;
      if (!m_run) begin
         if (st && !sp) m_run = 1;
         m_timer = 0;
      end else if (sp) begin
         m_run = 0;
         m_timer = 0;
      end else begin
         m_timer = (m_timer + 1) % E;
      end
      @(posedge clk);
      #1;
      m_valid = m_valid_nxt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 0; stop = 0; pop = 0; ace = 0; squash = 0; ib_duration = '0;
      avf_ready = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      m_valid = 0;
      reset_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sum"}, avf_sum, 0);
      chk({tag, "_nonace"}, avf_nonace_sum, 0);
      chk({tag, "_count"}, avf_count, 0);
      chk({tag, "_sat"}, avf_sat, 0);
      chk({tag, "_valid"}, avf_valid, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   // Monitor: valid tracking every cycle, payload check on each transfer.
   always @(negedge clk) begin
      snap_s e;
      if (mon_en) begin
         chk("valid_track", avf_valid, m_valid);
         if (avf_valid && avf_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_snapshot", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               chk("snap_sum", avf_sum, e.sum);
               chk("snap_count", avf_count, e.cnt);
               chk("snap_sat", avf_sat, e.sat);
               chk("snap_overrun", overrun, e.ovr);
`ifdef IB_AVF_NONACE_EN
               chk("snap_nonace", avf_nonace_sum, e.non);
`else
               chk("snap_nonace", avf_nonace_sum, 0);
`endif
            end
         end
      end
   end

   initial begin
      m_valid = 0;
      rdy = 0;
      do_reset();
      chk_all_zero("reset");
      mon_en = 1'b1;

      // Epoch length with no pops.
      rdy = 0;
      step(1, 0, 0, 0, 0, 0);
      idle(E - 1);
      chk("epoch_not_early", avf_valid, 0);
      idle(1);
      chk("epoch1_valid", avf_valid, 1);
      chk("epoch1_sum", avf_sum, 0);
      chk("epoch1_count", avf_count, 0);

      // ACE sum plus squashed pop, backpressure held across two epochs.
      step(0, 0, 1, 1, 0, 5);
      step(0, 0, 1, 1, 0, 10);
      step(0, 0, 1, 1, 0, 1023);
      step(0, 0, 1, 1, 1, 7);
      idle(E - 4);
      chk("epoch2_sum", avf_sum, 1038);
      chk("epoch2_count", avf_count, 3);
      chk("epoch2_overrun", overrun, 1);
`ifdef IB_AVF_NONACE_EN
      chk("epoch2_nonace", avf_nonace_sum, 7);
`endif

      // Saturation.
      rdy = 1; idle(1); rdy = 0;
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 1023);
      idle(E - 6);
      chk("sat_sum", avf_sum, MAXS);
      chk("sat_flag", avf_sat, 1);
      chk("sat_count", avf_count, 5);

      // Pop in the terminal cycle belongs to the closing epoch.
      rdy = 1; idle(1); rdy = 0;
      idle(E - 2);
      step(0, 0, 1, 1, 0, 9);
      chk("tc_sum", avf_sum, 9);
      chk("tc_count", avf_count, 1);
      chk("tc_sat_cleared", avf_sat, 0);

      // Stop mid-epoch, then pops in IDLE are ignored.
      rdy = 1;
      idle(1);
      step(0, 0, 1, 1, 0, 4);
      step(0, 0, 1, 1, 0, 4);
      step(0, 1, 0, 0, 0, 0);
      chk("stop_valid", avf_valid, 1);
      chk("stop_sum", avf_sum, 8);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 100);
      rdy = 0;
      step(1, 0, 0, 0, 0, 0);
      idle(E);
      chk("after_stop_sum", avf_sum, 0);
      chk("after_stop_count", avf_count, 0);

      // Reset mid-epoch discards everything.
      rdy = 1; idle(1); rdy = 0;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 50 + i);
      do_reset();
      chk_all_zero("midreset");
      idle(3 * E);
      chk("no_snap_after_reset", avf_valid, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit st, sp, p, a, sq;
         int d;
         rdy = ($urandom_range(0, 9) < 6);
         st  = ($urandom_range(0, 39) == 0);
         sp  = ($urandom_range(0, 59) == 0);
         p   = $urandom_range(0, 1);
         a   = ($urandom_range(0, 3) != 0);
         sq  = ($urandom_range(0, 7) == 0);
         d   = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(0, 1023);
         if ($urandom_range(0, 699) == 0) do_reset();
         else step(st, sp, p, a, sq, d);
      end

      // Drain.
      rdy = 1;
      step(0, 1, 0, 0, 0, 0);
      idle(4);
      chk("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
